// File: rtl/bus2_line_master.sv
// bus2_line_master: cache-side master of the bus2 C2/A2/D2 tri-state bus.
// It takes one whole-line read or write from the cache core, runs the
// command/data handshake with the memory controller, releases the bus at
// each turnaround and returns the read line (or write completion). A
// watchdog gives up with an error if the slave stays silent.
module bus2_line_master #(
  parameter int ADDR2_BUS_SIZE  = 14,
  parameter int DATA_BUS_SIZE   = 16,
  parameter int CTR2_BUS_SIZE   = 2,
  parameter int CACHE_LINE_SIZE = 16,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [ADDR2_BUS_SIZE-1:0]      req_addr,
  input  logic [8*CACHE_LINE_SIZE-1:0]   req_wdata,
  output logic                           resp_valid,
  output logic                           resp_err,
  output logic [8*CACHE_LINE_SIZE-1:0]   resp_rdata,
  inout  wire  [ADDR2_BUS_SIZE-1:0]      A2_WIRE,
  inout  wire  [DATA_BUS_SIZE-1:0]       D2_WIRE,
  inout  wire  [CTR2_BUS_SIZE-1:0]       C2_WIRE
);

  localparam int LINE_W = 8 * CACHE_LINE_SIZE;
  localparam int BEATS  = CACHE_LINE_SIZE / 2;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CTR2_BUS_SIZE-1:0] C2_NOP        = CTR2_BUS_SIZE'(0);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_RESPONSE   = CTR2_BUS_SIZE'(1);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_READ_LINE  = CTR2_BUS_SIZE'(2);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE_LINE = CTR2_BUS_SIZE'(3);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_W_DATA    = 3'd1,
    ST_W_TURN    = 3'd2,
    ST_R_CMD     = 3'd3,
    ST_R_TURN    = 3'd4,
    ST_WAIT_RESP = 3'd5,
    ST_R_DATA    = 3'd6,
    ST_DONE      = 3'd7
  } state_t;

  state_t                      state_q;
  logic [BEAT_W-1:0]           beat_q;
  logic [WD_W-1:0]             wd_q;
  logic                        write_q;
  logic [ADDR2_BUS_SIZE-1:0]   addr_q;
  logic [LINE_W-1:0]           wdata_q;
  logic [LINE_W-1:0]           rbuf_q;
  logic [CTR2_BUS_SIZE-1:0]    c2_q;
  logic [DATA_BUS_SIZE-1:0]    d2_q;
  logic                        c2_oe_q;
  logic                        a2_oe_q;
  logic                        d2_oe_q;
  logic                        req_ready_q;
  logic                        resp_valid_q;
  logic                        resp_err_q;
  logic [LINE_W-1:0]           resp_rdata_q;

  logic [CTR2_BUS_SIZE-1:0]    c2_in_s;
  logic [DATA_BUS_SIZE-1:0]    d2_in_s;
  logic                        rsp_s;
  logic [BEAT_W-1:0]           beat_d;
  logic [WD_W-1:0]             wd_d;
  logic [DATA_BUS_SIZE-1:0]    wbeat_d;
  logic [LINE_W-1:0]           rbuf_d;

  // Bus drivers come straight from registers; released lanes float.
  assign C2_WIRE = c2_oe_q ? c2_q   : {CTR2_BUS_SIZE{1'bz}};
  assign A2_WIRE = a2_oe_q ? addr_q : {ADDR2_BUS_SIZE{1'bz}};
  assign D2_WIRE = d2_oe_q ? d2_q   : {DATA_BUS_SIZE{1'bz}};

  assign c2_in_s = C2_WIRE;
  assign d2_in_s = D2_WIRE;
  // An X/Z command compares false here, so it never counts as a response.
  assign rsp_s   = (c2_in_s == C2_RESPONSE);

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

  assign beat_d  = beat_q + 1'b1;
  assign wd_d    = wd_q + 1'b1;
  assign wbeat_d = wdata_q[beat_d*DATA_BUS_SIZE +: DATA_BUS_SIZE];

  // Read line buffer with the beat currently on D2 merged into its slot.
  always_comb begin
    rbuf_d = rbuf_q;
    rbuf_d[beat_q*DATA_BUS_SIZE +: DATA_BUS_SIZE] = d2_in_s;
  end

  // Transaction FSM: sequences bus ownership, beats, watchdog and response.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      wd_q         <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rbuf_q       <= '0;
      c2_q         <= C2_NOP;
      d2_q         <= '0;
      c2_oe_q      <= 1'b0;
      a2_oe_q      <= 1'b0;
      d2_oe_q      <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            write_q     <= req_write;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            beat_q      <= '0;
            req_ready_q <= 1'b0;
            c2_oe_q     <= 1'b1;
            a2_oe_q     <= 1'b1;
            if (req_write) begin
              state_q <= ST_W_DATA;
              c2_q    <= C2_WRITE_LINE;
              d2_q    <= req_wdata[DATA_BUS_SIZE-1:0];
              d2_oe_q <= 1'b1;
            end else begin
              state_q <= ST_R_CMD;
              c2_q    <= C2_READ_LINE;
              d2_oe_q <= 1'b0;
            end
          end
        end
        ST_W_DATA: begin
          if (beat_q == LAST_BEAT) begin
            state_q <= ST_W_TURN;
            c2_q    <= C2_NOP;
            a2_oe_q <= 1'b0;
            d2_oe_q <= 1'b0;
          end else begin
            beat_q <= beat_d;
            d2_q   <= wbeat_d;
          end
        end
        ST_W_TURN: begin
          state_q <= ST_WAIT_RESP;
          c2_oe_q <= 1'b0;
          wd_q    <= '0;
        end
        ST_R_CMD: begin
          state_q <= ST_R_TURN;
          c2_q    <= C2_NOP;
          a2_oe_q <= 1'b0;
        end
        ST_R_TURN: begin
          state_q <= ST_WAIT_RESP;
          c2_oe_q <= 1'b0;
          wd_q    <= '0;
        end
        ST_WAIT_RESP: begin
          if (rsp_s) begin
            wd_q <= '0;
            if (write_q) begin
              state_q      <= ST_DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
            end else begin
              // The first response edge of a read already carries beat 0.
              rbuf_q[DATA_BUS_SIZE-1:0] <= d2_in_s;
              beat_q  <= BEAT_W'(1);
              state_q <= ST_R_DATA;
            end
          end else if (wd_d == WD_LIMIT) begin
            state_q      <= ST_DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
          end else begin
            wd_q <= wd_d;
          end
        end
        ST_R_DATA: begin
          if (rsp_s) begin
            wd_q   <= '0;
            rbuf_q <= rbuf_d;
            if (beat_q == LAST_BEAT) begin
              resp_rdata_q <= rbuf_d;
              state_q      <= ST_DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
            end else begin
              beat_q <= beat_d;
            end
          end else if (wd_d == WD_LIMIT) begin
            // Partial line is discarded; the last good line stays visible.
            state_q      <= ST_DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
          end else begin
            wd_q <= wd_d;
          end
        end
        ST_DONE: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          c2_oe_q     <= 1'b0;
          a2_oe_q     <= 1'b0;
          d2_oe_q     <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus2_line_master.sv
// Directed testbench for bus2_line_master with a hand-driven bus2 slave.
// Released bus lanes are pulled high, so a floating bus reads all ones.
module tb_bus2_line_master;

  localparam int AW = 14;
  localparam int DW = 16;
  localparam int CW = 2;
  localparam int LS = 16;
  localparam int TO = 10;

  localparam logic [31:0]   BUS_FREE = 32'hFFFF_FFFF;
  localparam logic [127:0]  WR_LINE  = 128'h1F1E1D1C1B1A19181716151413121110;
  localparam logic [127:0]  RD_LINE  = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0]  GAP_LINE = 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0;
  localparam logic [127:0]  RST_LINE = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0]  WR2_LINE = 128'hC3C2C1C0B3B2B1B0A3A2A1A093929190;
  localparam logic [127:0]  B2B_WR   = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0]  B2B_RD   = 128'h8F8E8D8C8B8A89888786858483828180;

  logic            CLK = 1'b0;
  logic            RESET = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_write = 1'b0;
  logic [AW-1:0]   req_addr = '0;
  logic [8*LS-1:0] req_wdata = '0;
  logic            resp_valid;
  logic            resp_err;
  logic [8*LS-1:0] resp_rdata;
  wire  [AW-1:0]   A2_WIRE;
  wire  [DW-1:0]   D2_WIRE;
  wire  [CW-1:0]   C2_WIRE;

  logic            slv_c2_oe = 1'b0;
  logic [CW-1:0]   slv_c2 = '0;
  logic            slv_d2_oe = 1'b0;
  logic [DW-1:0]   slv_d2 = '0;

  int tests_run = 0;
  int tests_failed = 0;

  assign C2_WIRE = slv_c2_oe ? slv_c2 : {CW{1'bz}};
  assign D2_WIRE = slv_d2_oe ? slv_d2 : {DW{1'bz}};
  pullup pu_a (A2_WIRE);
  pullup pu_d (D2_WIRE);
  pullup pu_c (C2_WIRE);

  bus2_line_master #(
    .ADDR2_BUS_SIZE(AW), .DATA_BUS_SIZE(DW), .CTR2_BUS_SIZE(CW),
    .CACHE_LINE_SIZE(LS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .A2_WIRE(A2_WIRE), .D2_WIRE(D2_WIRE), .C2_WIRE(C2_WIRE)
  );

  always #5 CLK = ~CLK;

  task automatic slave_drive(input logic [CW-1:0] c2, input logic [DW-1:0] d2);
    slv_c2 = c2; slv_d2 = d2; slv_c2_oe = 1'b1; slv_d2_oe = 1'b1;
  endtask

  task automatic slave_release();
    slv_c2_oe = 1'b0; slv_d2_oe = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    tests_run++;
    if ({C2_WIRE, A2_WIRE, D2_WIRE} !== BUS_FREE) begin
      tests_failed++; $display("FAIL rst_bus got=%h exp=%h", {C2_WIRE, A2_WIRE, D2_WIRE}, BUS_FREE);
    end
    tests_run++;
    if ({req_ready, resp_valid, resp_err} !== 3'b100) begin
      tests_failed++; $display("FAIL rst_flags got=%b exp=100", {req_ready, resp_valid, resp_err});
    end
    tests_run++;
    if (resp_rdata !== 128'd0) begin
      tests_failed++; $display("FAIL rst_rdata got=%h exp=0", resp_rdata);
    end
    RESET = 1'b1;
    @(negedge CLK);
  endtask

  task automatic run_write(input logic [AW-1:0] addr, input logic [127:0] line, input int gap);
    @(negedge CLK);
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = line;
    @(negedge CLK);
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge CLK);
      tests_run++;
      if ({C2_WIRE, A2_WIRE, D2_WIRE, req_ready} !== {2'd3, addr, line[i*16 +: 16], 1'b0}) begin
        tests_failed++;
        $display("FAIL wr_beat%0d got c2=%h a2=%h d2=%h rdy=%b exp c2=3 a2=%h d2=%h rdy=0",
                 i, C2_WIRE, A2_WIRE, D2_WIRE, req_ready, addr, line[i*16 +: 16]);
      end
    end
    @(negedge CLK);
    tests_run++;
    if ({C2_WIRE, A2_WIRE, D2_WIRE} !== {2'd0, 14'h3FFF, 16'hFFFF}) begin
      tests_failed++; $display("FAIL wr_turn got=%h exp=%h", {C2_WIRE, A2_WIRE, D2_WIRE}, {2'd0, 14'h3FFF, 16'hFFFF});
    end
    @(negedge CLK);
    tests_run++;
    if ({C2_WIRE, A2_WIRE, D2_WIRE} !== BUS_FREE) begin
      tests_failed++; $display("FAIL wr_release got=%h exp=%h", {C2_WIRE, A2_WIRE, D2_WIRE}, BUS_FREE);
    end
    for (int j = 1; j < gap; j++) begin
      @(negedge CLK);
      tests_run++;
      if (resp_valid !== 1'b0) begin
        tests_failed++; $display("FAIL wr_early_resp cycle%0d got=%b exp=0", j, resp_valid);
      end
    end
    slave_drive(2'd1, 16'h0000);
    @(negedge CLK);
    slave_release();
    tests_run++;
    if ({resp_valid, resp_err, req_ready} !== 3'b100) begin
      tests_failed++; $display("FAIL wr_resp got=%b exp=100", {resp_valid, resp_err, req_ready});
    end
    @(negedge CLK);
    tests_run++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      tests_failed++; $display("FAIL wr_idle got=%b exp=01", {resp_valid, req_ready});
    end
  endtask

  task automatic run_read(input logic [AW-1:0] addr, input logic [127:0] line, input int ngap);
    @(negedge CLK);
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
    @(negedge CLK);
    req_valid = 1'b0;
    tests_run++;
    if ({C2_WIRE, A2_WIRE, D2_WIRE, req_ready} !== {2'd2, addr, 16'hFFFF, 1'b0}) begin
      tests_failed++; $display("FAIL rd_cmd got c2=%h a2=%h d2=%h rdy=%b exp c2=2 a2=%h d2=ffff rdy=0",
                               C2_WIRE, A2_WIRE, D2_WIRE, req_ready, addr);
    end
    @(negedge CLK);
    tests_run++;
    if ({C2_WIRE, A2_WIRE, D2_WIRE} !== {2'd0, 14'h3FFF, 16'hFFFF}) begin
      tests_failed++; $display("FAIL rd_turn got=%h exp=%h", {C2_WIRE, A2_WIRE, D2_WIRE}, {2'd0, 14'h3FFF, 16'hFFFF});
    end
    @(negedge CLK);
    tests_run++;
    if ({C2_WIRE, A2_WIRE, D2_WIRE} !== BUS_FREE) begin
      tests_failed++; $display("FAIL rd_release got=%h exp=%h", {C2_WIRE, A2_WIRE, D2_WIRE}, BUS_FREE);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        for (int g = 0; g < ngap; g++) begin
          slave_drive(2'd0, 16'hDEAD);
          @(negedge CLK);
          tests_run++;
          if (resp_valid !== 1'b0) begin
            tests_failed++; $display("FAIL rd_gap%0d_resp got=%b exp=0", g, resp_valid);
          end
        end
      end
      slave_drive(2'd1, line[i*16 +: 16]);
      @(negedge CLK);
      if (i < 7) begin
        tests_run++;
        if (resp_valid !== 1'b0) begin
          tests_failed++; $display("FAIL rd_beat%0d_resp got=%b exp=0", i, resp_valid);
        end
      end
    end
    slave_release();
    tests_run++;
    if ({resp_valid, resp_err} !== 2'b10) begin
      tests_failed++; $display("FAIL rd_resp got=%b exp=10", {resp_valid, resp_err});
    end
    tests_run++;
    if (resp_rdata !== line) begin
      tests_failed++; $display("FAIL rd_data got=%h exp=%h", resp_rdata, line);
    end
    @(negedge CLK);
    tests_run++;
    if ({resp_valid, req_ready} !== 2'b01 || resp_rdata !== line) begin
      tests_failed++; $display("FAIL rd_idle got vr=%b data=%h exp vr=01 data=%h",
                               {resp_valid, req_ready}, resp_rdata, line);
    end
  endtask

  task automatic test_write();
    run_write(14'h0A5, WR_LINE, 6);
  endtask

  task automatic test_read();
    run_read(14'h003, RD_LINE, 0);
  endtask

  task automatic test_read_gaps();
    run_read(14'h2A7, GAP_LINE, 2);
  endtask

  task automatic test_timeout();
    int cnt;
    @(negedge CLK);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 14'h111;
    @(negedge CLK);
    req_valid = 1'b0;
    repeat (2) @(negedge CLK);
    cnt = 0;
    while (cnt < 30 && resp_valid !== 1'b1) begin
      @(negedge CLK);
      cnt++;
    end
    tests_run++;
    if (cnt !== TO) begin
      tests_failed++; $display("FAIL to_latency got=%0d exp=%0d", cnt, TO);
    end
    tests_run++;
    if ({resp_valid, resp_err} !== 2'b11) begin
      tests_failed++; $display("FAIL to_err got=%b exp=11", {resp_valid, resp_err});
    end
    tests_run++;
    if (resp_rdata !== GAP_LINE) begin
      tests_failed++; $display("FAIL to_rdata got=%h exp=%h", resp_rdata, GAP_LINE);
    end
    @(negedge CLK);
    tests_run++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      tests_failed++; $display("FAIL to_idle got=%b exp=01", {resp_valid, req_ready});
    end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 14'h155; req_wdata = RST_LINE;
    @(negedge CLK);
    req_valid = 1'b0;
    repeat (3) @(negedge CLK);
    tests_run++;
    if (D2_WIRE !== RST_LINE[48 +: 16]) begin
      tests_failed++; $display("FAIL rm_beat3 got=%h exp=%h", D2_WIRE, RST_LINE[48 +: 16]);
    end
    RESET = 1'b0;
    #1;
    tests_run++;
    if ({C2_WIRE, A2_WIRE, D2_WIRE} !== BUS_FREE) begin
      tests_failed++; $display("FAIL rm_bus got=%h exp=%h", {C2_WIRE, A2_WIRE, D2_WIRE}, BUS_FREE);
    end
    tests_run++;
    if ({req_ready, resp_valid} !== 2'b10 || resp_rdata !== 128'd0) begin
      tests_failed++; $display("FAIL rm_flags got rv=%b data=%h exp rv=10 data=0", {req_ready, resp_valid}, resp_rdata);
    end
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      tests_run++;
      if (resp_valid !== 1'b0 || A2_WIRE !== 14'h3FFF) begin
        tests_failed++; $display("FAIL rm_quiet%0d got v=%b a2=%h exp v=0 a2=3fff", i, resp_valid, A2_WIRE);
      end
    end
    run_write(14'h2C3, WR2_LINE, 2);
  endtask

  task automatic test_back_to_back();
    @(negedge CLK);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 14'h0F0; req_wdata = B2B_WR;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      tests_run++;
      if (req_ready !== 1'b0) begin
        tests_failed++; $display("FAIL b2b_ready%0d got=%b exp=0", i, req_ready);
      end
    end
    slave_drive(2'd1, 16'h0000);
    @(negedge CLK);
    slave_release();
    tests_run++;
    if ({resp_valid, resp_err, req_ready} !== 3'b100) begin
      tests_failed++; $display("FAIL b2b_resp1 got=%b exp=100", {resp_valid, resp_err, req_ready});
    end
    req_write = 1'b0; req_addr = 14'h1E1;
    @(negedge CLK);
    tests_run++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      tests_failed++; $display("FAIL b2b_ready2 got=%b exp=01", {resp_valid, req_ready});
    end
    @(negedge CLK);
    req_valid = 1'b0;
    tests_run++;
    if ({C2_WIRE, A2_WIRE, req_ready} !== {2'd2, 14'h1E1, 1'b0}) begin
      tests_failed++; $display("FAIL b2b_accept2 got c2=%h a2=%h rdy=%b exp c2=2 a2=1e1 rdy=0", C2_WIRE, A2_WIRE, req_ready);
    end
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      slave_drive(2'd1, B2B_RD[i*16 +: 16]);
      @(negedge CLK);
    end
    slave_release();
    tests_run++;
    if ({resp_valid, resp_err} !== 2'b10 || resp_rdata !== B2B_RD) begin
      tests_failed++; $display("FAIL b2b_rd got ve=%b data=%h exp ve=10 data=%h", {resp_valid, resp_err}, resp_rdata, B2B_RD);
    end
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_read_gaps();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish, got=running exp=done");
    $fatal(1, "global timeout");
  end

endmodule
